// File: rtl/mp_intr_pkg.sv
// Shared types and helpers for the multi-process interrupt arbiter.
// INTR_TIMEOUT_EN adds the GAP state used for ack-timeout re-issue.
package mp_intr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2
`ifdef INTR_TIMEOUT_EN
    , ST_GAP   = 2'd3
`endif
  } state_e;

  function automatic int eng_id_w(int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic [7:0] sat_inc8(logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mp_rr_arbiter.sv
// Combinational round-robin pick: first eligible bit above last_grant_i,
// wrapping at N.
module mp_rr_arbiter #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] eligible_i,
  input  logic [W-1:0] last_grant_i,
  output logic         valid_o,
  output logic [W-1:0] index_o
);

  int j;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    valid_o = 1'b0;
    index_o = '0;
    j       = 0;
    for (int i = N; i >= 1; i--) begin
      j = (int'(last_grant_i) + i) % N;
      if (eligible_i[j]) begin
        valid_o = 1'b1;
        index_o = W'(j);
      end
    end
  end

endmodule

// File: rtl/mp_intr_arbiter.sv
// Serialises per-engine interrupt requests onto one interrupt/ack pair.
// Optional INTR_TIMEOUT_EN: re-issue the interrupt when no ack arrives.
module mp_intr_arbiter
  import mp_intr_pkg::*;
#(
  parameter int ENGINE_NUM     = 8,
  parameter int CONTEXT_BITS   = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ENG_ID_W       = eng_id_w(ENGINE_NUM)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ENGINE_NUM-1:0]            i_eng_irq_req,
  input  logic [ENGINE_NUM*CONTEXT_BITS-1:0] i_eng_ctx,
  input  logic [ENGINE_NUM-1:0]            i_enable,
  output logic [ENGINE_NUM-1:0]            o_eng_irq_done,
  output logic                             o_interrupt,
  output logic [ENG_ID_W-1:0]              o_int_src,
  output logic [CONTEXT_BITS-1:0]          o_int_ctx,
  input  logic                             i_interrupt_ack,
  output logic [ENGINE_NUM-1:0]            o_pending,
  output logic [7:0]                       o_stray_ack_cnt,
  output logic [7:0]                       o_retry_cnt
);

  state_e                  state_q;
  logic [ENG_ID_W-1:0]     last_q, src_q;
  logic [CONTEXT_BITS-1:0] ctx_q;
  logic                    int_q;
  logic [ENGINE_NUM-1:0]   done_q, pend_q;
  logic [7:0]              stray_q;
  logic                    pick_vld;
  logic [ENG_ID_W-1:0]     pick_idx;
  logic [ENGINE_NUM-1:0]   eligible_d;

  assign eligible_d = i_eng_irq_req & i_enable;

  mp_rr_arbiter #(.N(ENGINE_NUM), .W(ENG_ID_W)) u_rr (
    .eligible_i   (eligible_d),
    .last_grant_i (last_q),
    .valid_o      (pick_vld),
    .index_o      (pick_idx)
  );

`ifdef INTR_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_q;
  logic [7:0]  retry_q;
  assign o_retry_cnt = retry_q;
`else
  assign o_retry_cnt = 8'h00;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= ENG_ID_W'(ENGINE_NUM - 1);
      src_q   <= '0;
      ctx_q   <= '0;
      int_q   <= 1'b0;
      done_q  <= '0;
      pend_q  <= '0;
      stray_q <= '0;
`ifdef INTR_TIMEOUT_EN
      tmo_q   <= '0;
      retry_q <= '0;
`endif
    end else begin
      pend_q <= eligible_d;
      done_q <= '0;
      if (i_interrupt_ack && state_q != ST_ASSERT) stray_q <= sat_inc8(stray_q);
      case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            src_q   <= pick_idx;
            ctx_q   <= i_eng_ctx[int'(pick_idx)*CONTEXT_BITS +: CONTEXT_BITS];
            last_q  <= pick_idx;
            int_q   <= 1'b1;
            state_q <= ST_ASSERT;
          end
        end
        ST_ASSERT: begin
          // Ack wins over a same-cycle timeout expiry.
          if (i_interrupt_ack) begin
            for (int i = 0; i < ENGINE_NUM; i++) done_q[i] <= (src_q == ENG_ID_W'(i));
            int_q   <= 1'b0;
            state_q <= ST_RELEASE;
`ifdef INTR_TIMEOUT_EN
            tmo_q   <= '0;
          end else if (tmo_q == TMO_LAST) begin
            int_q   <= 1'b0;
            tmo_q   <= '0;
            retry_q <= sat_inc8(retry_q);
            state_q <= ST_GAP;
          end else begin
            tmo_q   <= tmo_q + 16'd1;
`endif
          end
        end
        ST_RELEASE: state_q <= ST_IDLE;
`ifdef INTR_TIMEOUT_EN
        ST_GAP: begin
          int_q   <= 1'b1;
          state_q <= ST_ASSERT;
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_interrupt     = int_q;
  assign o_int_src       = src_q;
  assign o_int_ctx       = ctx_q;
  assign o_eng_irq_done  = done_q;
  assign o_pending       = pend_q;
  assign o_stray_ack_cnt = stray_q;

endmodule
